// File: rtl/mod_compress_core.sv
// SHA-256 compression core: loads H from the shared H/K port, runs 64 rounds on streamed W[t], emits the digest.
// Optional block chaining (CHAIN input, H reloaded from DIGEST) is enabled by defining COMPRESS_CHAIN_EN.
module mod_compress_core #(
    parameter int HK_LAT = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
`ifdef COMPRESS_CHAIN_EN
    input  logic         CHAIN,
`endif
    input  logic         HK_READY,
    output logic         HK_SELECTOR,
    output logic [2:0]   H_ADDR,
    output logic [5:0]   K_ADDR,
    input  logic [31:0]  HK,
    input  logic         W_VALID,
    input  logic [31:0]  W,
    output logic         W_READY,
    output logic         BUSY,
    output logic         DONE,
    output logic [255:0] DIGEST
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD_H, S_ROUND, S_FINAL} state_t;

    localparam logic [3:0] LAT    = 4'(HK_LAT);
    localparam logic [3:0] LAT_M1 = 4'(HK_LAT - 1);

    state_t      state;
    logic        pending;
    logic [3:0]  cnt;
    logic [31:0] h_reg [8];
    logic [31:0] wk    [8];
    logic [31:0] t1, t2;
    logic        chain_now;

`ifdef COMPRESS_CHAIN_EN
    logic chain_q;
    assign chain_now = START ? CHAIN : chain_q;
`else
    assign chain_now = 1'b0;
`endif

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Round function on the current working set; wk[0..7] = a..h
    assign t1 = wk[7] + big_s1(wk[4]) + ch(wk[4], wk[5], wk[6]) + HK + W;
    assign t2 = big_s0(wk[0]) + maj(wk[0], wk[1], wk[2]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            pending     <= 1'b0;
            cnt         <= '0;
            HK_SELECTOR <= 1'b0;
            H_ADDR      <= '0;
            K_ADDR      <= '0;
            W_READY     <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            DIGEST      <= '0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= '0;
                wk[i]    <= '0;
            end
`ifdef COMPRESS_CHAIN_EN
            chain_q     <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef COMPRESS_CHAIN_EN
                    if (START) chain_q <= CHAIN;
`endif
                    if ((pending || START) && HK_READY) begin
                        pending <= 1'b0;
                        BUSY    <= 1'b1;
                        cnt     <= '0;
                        if (chain_now) begin
                            for (int i = 0; i < 8; i++) begin
                                h_reg[i] <= DIGEST[255 - 32*i -: 32];
                                wk[i]    <= DIGEST[255 - 32*i -: 32];
                            end
                            HK_SELECTOR <= 1'b1;
                            K_ADDR      <= '0;
                            state       <= S_ROUND;
                        end else begin
                            state <= S_LOAD_H;
                        end
                    end else if (START) begin
                        pending <= 1'b1;
                    end
                end
                // Each H address is held HK_LAT+1 cycles before its word is captured
                S_LOAD_H: begin
                    if (!HK_READY) begin
                        cnt <= '0;
                    end else if (cnt == LAT) begin
                        h_reg[H_ADDR] <= HK;
                        wk[H_ADDR]    <= HK;
                        cnt           <= '0;
                        H_ADDR        <= H_ADDR + 3'd1;
                        if (H_ADDR == 3'd7) begin
                            HK_SELECTOR <= 1'b1;
                            K_ADDR      <= '0;
                            state       <= S_ROUND;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                // W_READY doubles as the K-valid flag; the last round also folds the result into DIGEST
                S_ROUND: begin
                    if (W_READY && W_VALID) begin
                        wk[0]   <= t1 + t2;
                        wk[1]   <= wk[0];
                        wk[2]   <= wk[1];
                        wk[3]   <= wk[2];
                        wk[4]   <= wk[3] + t1;
                        wk[5]   <= wk[4];
                        wk[6]   <= wk[5];
                        wk[7]   <= wk[6];
                        K_ADDR  <= K_ADDR + 6'd1;
                        W_READY <= 1'b0;
                        cnt     <= '0;
                        if (K_ADDR == 6'd63) begin
                            state  <= S_FINAL;
                            DONE   <= 1'b1;
                            DIGEST <= {h_reg[0] + t1 + t2, h_reg[1] + wk[0],
                                       h_reg[2] + wk[1],   h_reg[3] + wk[2],
                                       h_reg[4] + wk[3] + t1, h_reg[5] + wk[4],
                                       h_reg[6] + wk[5],   h_reg[7] + wk[6]};
                        end
                    end else if (!HK_READY) begin
                        W_READY <= 1'b0;
                        cnt     <= '0;
                    end else if (!W_READY) begin
                        if (cnt == LAT_M1) W_READY <= 1'b1;
                        else               cnt     <= cnt + 4'd1;
                    end
                end
                S_FINAL: begin
                    state       <= S_IDLE;
                    BUSY        <= 1'b0;
                    HK_SELECTOR <= 1'b0;
                    H_ADDR      <= '0;
                    K_ADDR      <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_compress_core.sv
// Directed bench for mod_compress_core with a registered H/K memory model and reference-schedule W source.
// Define COMPRESS_CHAIN_EN to also exercise two-block chaining.
module tb_mod_compress_core;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] H_INIT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};

    logic         clk = 1'b0;
    logic         rst, start, hk_ready, w_valid;
    logic [31:0]  w, hk;
    logic         hk_sel, w_ready, busy, done;
    logic [2:0]   h_addr;
    logic [5:0]   k_addr;
    logic [255:0] digest;
`ifdef COMPRESS_CHAIN_EN
    logic         chain;
`endif

    logic [31:0] sched [64];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mod_compress_core #(.HK_LAT(1)) dut (
        .CLK         (clk),
        .RST         (rst),
        .START       (start),
`ifdef COMPRESS_CHAIN_EN
        .CHAIN       (chain),
`endif
        .HK_READY    (hk_ready),
        .HK_SELECTOR (hk_sel),
        .H_ADDR      (h_addr),
        .K_ADDR      (k_addr),
        .HK          (hk),
        .W_VALID     (w_valid),
        .W           (w),
        .W_READY     (w_ready),
        .BUSY        (busy),
        .DONE        (done),
        .DIGEST      (digest)
    );

    // One-cycle registered read, like MOD_HK_MEM
    always @(posedge clk) hk <= hk_sel ? K_ROM[k_addr] : H_INIT[h_addr];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic load_block(input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) sched[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(sched[i-15], 7) ^ rr(sched[i-15], 18) ^ (sched[i-15] >> 3);
            s1 = rr(sched[i-2], 17) ^ rr(sched[i-2], 19) ^ (sched[i-2] >> 10);
            sched[i] = sched[i-16] + s0 + sched[i-7] + s1;
        end
    endtask

    // Feeds W on handshake; returns at the negedge where DONE is seen (cycle 1 = START cycle),
    // or at round abort_t (done_cyc = -2) so the caller can assert RST mid-block.
    task automatic run_block(input bit do_start, input bit stall_en, input int abort_t, output int done_cyc);
        int widx = 0;
        int stall_left = 0;
        bit s20 = 1'b0;
        bit s63 = 1'b0;
        done_cyc = -1;
        if (do_start) start = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (abort_t >= 0 && widx == abort_t) begin
                done_cyc = -2;
                break;
            end
            if (stall_en && w_ready && stall_left == 0 &&
                ((widx == 20 && !s20) || (widx == 63 && !s63))) begin
                stall_left = (widx == 20) ? 5 : 1;
                if (widx == 20) s20 = 1'b1;
                else            s63 = 1'b1;
            end
            w = (widx < 64) ? sched[widx] : 32'h0;
            if (stall_left > 0) begin
                w_valid = 1'b0;
                stall_left--;
                chk("k_addr_stall", 256'(k_addr), 256'(widx));
            end else begin
                w_valid = 1'b1;
            end
            if (w_ready && w_valid) widx++;
            @(negedge clk);
            start = 1'b0;
        end
        if (done_cyc == -1) chk("done_timeout", 256'(done), 256'(1));
    endtask

    // Called at the DONE negedge: checks the digest, drives a START into FINAL, then checks the return to IDLE.
    task automatic finish_checks(input string tag, input logic [255:0] exp_dig);
        chk({tag, "_done"}, 256'(done), 256'(1));
        chk({tag, "_digest"}, digest, exp_dig);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_idle_busy"}, 256'(busy), 256'(0));
        chk({tag, "_idle_done"}, 256'(done), 256'(0));
        chk({tag, "_idle_sel"}, 256'(hk_sel), 256'(0));
        chk({tag, "_idle_kaddr"}, 256'(k_addr), 256'(0));
        chk({tag, "_idle_haddr"}, 256'(h_addr), 256'(0));
        chk({tag, "_digest_held"}, digest, exp_dig);
        @(negedge clk);
        chk({tag, "_final_start_ignored"}, 256'(busy), 256'(0));
    endtask

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; hk_ready = 1'b1; w_valid = 1'b0; w = 32'h0;
`ifdef COMPRESS_CHAIN_EN
        chain = 1'b0;
`endif
        // Reset held for three edges, then idle without START
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_wready", 256'(w_ready), 256'(0));
        chk("rst_sel", 256'(hk_sel), 256'(0));
        chk("rst_haddr", 256'(h_addr), 256'(0));
        chk("rst_kaddr", 256'(k_addr), 256'(0));
        chk("rst_digest", digest, 256'h0);
        repeat (5) @(negedge clk);
        chk("idle_haddr", 256'(h_addr), 256'(0));
        chk("idle_kaddr", 256'(k_addr), 256'(0));
        chk("idle_busy", 256'(busy), 256'(0));

        // "abc", W always valid
        load_block(BLK_ABC);
        run_block(1'b1, 1'b0, -1, dc);
        chk("abc_done_cycle", 256'(dc), 256'(146));
        finish_checks("abc", DIG_ABC);

        // "abc" with W_VALID stalls at t=20 (5 cycles) and t=63 (1 cycle)
        run_block(1'b1, 1'b1, -1, dc);
        chk("stall_done_cycle", 256'(dc), 256'(152));
        finish_checks("stall", DIG_ABC);

        // START while HK_READY low waits in IDLE
        hk_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("hkwait_busy", 256'(busy), 256'(0));
            chk("hkwait_haddr", 256'(h_addr), 256'(0));
            chk("hkwait_sel", 256'(hk_sel), 256'(0));
            @(negedge clk);
        end
        hk_ready = 1'b1;
        @(negedge clk);
        chk("hkwait_load_busy", 256'(busy), 256'(1));
        run_block(1'b0, 1'b0, -1, dc);
        finish_checks("hkwait", DIG_ABC);

        // Abort at t=30, then the empty message
        run_block(1'b1, 1'b0, 30, dc);
        chk("abort_kaddr_pre", 256'(k_addr), 256'(30));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_digest", digest, 256'h0);
        chk("abort_kaddr", 256'(k_addr), 256'(0));
        chk("abort_sel", 256'(hk_sel), 256'(0));
        chk("abort_wready", 256'(w_ready), 256'(0));
        load_block(BLK_EMPTY);
        run_block(1'b1, 1'b0, -1, dc);
        chk("empty_done_cycle", 256'(dc), 256'(146));
        finish_checks("empty", DIG_EMPTY);

`ifdef COMPRESS_CHAIN_EN
        // Two-block message, second block chained from DIGEST
        load_block({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000});
        chain = 1'b0;
        run_block(1'b1, 1'b0, -1, dc);
        chk("chain_b1_done", 256'(done), 256'(1));
        @(negedge clk);
        load_block({480'h0, 32'h000001c0});
        chain = 1'b1;
        run_block(1'b1, 1'b0, -1, dc);
        chain = 1'b0;
        chk("chain_done_cycle", 256'(dc), 256'(130));
        chk("chain_digest", digest, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
